keycode_dispatcher: RTL

Converts the raw 8-bit USB HID keycode produced by the game SoC's keycode PIO into a debounced stream of press/release events and per-frame player direction state for the game logic. It sits between the SoC's keycode output and the game engine and game-state FSMs. It sequences every keycode change into at most two ordered events: release of the old code, then press of the new one. A small FIFO absorbs bursts, and a valid/ready handshake lets a consumer drain events at its own pace.

---
 rtl/keycode_pkg.sv | 37 +++
 rtl/event_fifo.sv | 55 +++++
 rtl/keycode_dispatcher.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/keycode_pkg.sv
// Shared types and constants for the keycode dispatcher.
// Direction keycodes, event format and FSM state encoding.
package keycode_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_REL,
      ST_PRS
   } state_e;

   typedef struct packed {
      logic       press;
      logic [7:0] code;
   } event_t;

   localparam logic [7:0] KEY_NONE     = 8'h00;
   localparam logic [7:0] KEY_P1_UP    = 8'h1A;
   localparam logic [7:0] KEY_P1_LEFT  = 8'h04;
   localparam logic [7:0] KEY_P1_DOWN  = 8'h16;
   localparam logic [7:0] KEY_P1_RIGHT = 8'h07;
   localparam logic [7:0] KEY_P2_UP    = 8'h52;
   localparam logic [7:0] KEY_P2_LEFT  = 8'h50;
   localparam logic [7:0] KEY_P2_DOWN  = 8'h51;
   localparam logic [7:0] KEY_P2_RIGHT = 8'h4F;

   // One-hot {up,left,down,right} for a given key set.
   function automatic logic [3:0] dir_decode(
      input logic [7:0] code,
      input logic [7:0] up,
      input logic [7:0] left,
      input logic [7:0] down,
      input logic [7:0] right
   );
      return {code == up, code == left, code == down, code == right};
   endfunction

endpackage

// File: rtl/event_fifo.sv
// Circular event buffer with wrapping pointers.
// A pop frees a slot for a push in the same cycle.
module event_fifo
   import keycode_pkg::*;
#(
   parameter int DEPTH = 8,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic   clk,
   input  logic   rst_n,
   input  logic   push_i,
   input  event_t data_i,
   input  logic   pop_i,
   output event_t data_o,
   output logic   full_o,
   output logic   empty_o,
   output logic [AW:0] count_o
);

   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   event_t        mem_q [DEPTH];
   logic [AW-1:0] wr_q;
   logic [AW-1:0] rd_q;
   logic [AW:0]   cnt_q;
   logic          do_push;
   logic          do_pop;

   assign empty_o = (cnt_q == '0);
   assign full_o  = (cnt_q == FULL_CNT);
   assign count_o = cnt_q;
   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);
   assign data_o  = empty_o ? '0 : mem_q[rd_q];

   // Pointer and occupancy bookkeeping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (do_push) wr_q <= wr_q + 1'b1;
         if (do_pop)  rd_q <= rd_q + 1'b1;
         if (do_push && !do_pop) cnt_q <= cnt_q + 1'b1;
         else if (do_pop && !do_push) cnt_q <= cnt_q - 1'b1;
      end
   end

   // Storage array; contents are don't-care until written.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_q] <= data_i;
   end

endmodule

// File: rtl/keycode_dispatcher.sv
// Debounces raw HID keycodes into ordered release/press events
// and latches per-frame direction state for two players.
module keycode_dispatcher
   import keycode_pkg::*;
#(
   parameter int STABLE_CYCLES = 16,
   parameter int DEPTH = 8
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [7:0] keycode,
   input  logic       frame_tick,
   output logic       ev_valid,
   output logic [8:0] ev_data,
   input  logic       ev_ready,
   output logic [3:0] p1_dir,
   output logic [3:0] p2_dir,
   output logic       overflow,
   output logic [7:0] drop_cnt,
   input  logic       clr
);

   localparam int          CW       = $clog2(DEPTH) + 1;
   localparam logic [7:0]  STAB_MAX = 8'(STABLE_CYCLES);
   localparam logic [7:0]  STAB_ACC = 8'(STABLE_CYCLES - 1);

   state_e      state_q, state_d;
   logic [7:0]  cand_q, stab_q;
   logic [7:0]  cur_q, cur_d;
   logic [7:0]  new_q, new_d;
   logic [7:0]  old_q, old_d;
   logic        accept;
   logic        push;
   event_t      push_ev;
   event_t      fifo_dout;
   logic        fifo_full, fifo_empty;
   logic [CW-1:0] fifo_cnt;
   logic        drop;
   logic        ovf_q;
   logic [7:0]  drop_q;
   logic [3:0]  p1_q, p2_q;

   // Stability filter: restart on any change, saturate when held.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cand_q <= KEY_NONE;
         stab_q <= '0;
      end else if (keycode != cand_q) begin
         cand_q <= keycode;
         stab_q <= '0;
      end else if (stab_q != STAB_MAX) begin
         stab_q <= stab_q + 8'd1;
      end
   end

   // Saturated count keeps a pending change acceptable once IDLE returns.
   assign accept = (stab_q >= STAB_ACC) && (cand_q == keycode) &&
                   (cand_q != cur_q) && (state_q == ST_IDLE);

   // FSM state and sequencing registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         cur_q   <= KEY_NONE;
         new_q   <= KEY_NONE;
         old_q   <= KEY_NONE;
      end else begin
         state_q <= state_d;
         cur_q   <= cur_d;
         new_q   <= new_d;
         old_q   <= old_d;
      end
   end

   // Next state: release first when a key was held, then press.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: if (accept) state_d = (cur_q != KEY_NONE) ? ST_REL : ST_PRS;
         ST_REL:  state_d = (new_q != KEY_NONE) ? ST_PRS : ST_IDLE;
         ST_PRS:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // FSM outputs: event pushes and current-key bookkeeping.
   always_comb begin
      push    = 1'b0;
      push_ev = '0;
      cur_d   = cur_q;
      new_d   = new_q;
      old_d   = old_q;
      unique case (state_q)
         ST_IDLE: begin
            if (accept) begin
               new_d = cand_q;
               old_d = cur_q;
            end
         end
         ST_REL: begin
            push    = 1'b1;
            push_ev = '{press: 1'b0, code: old_q};
            if (new_q == KEY_NONE) cur_d = new_q;
         end
         ST_PRS: begin
            push    = 1'b1;
            push_ev = '{press: 1'b1, code: new_q};
            cur_d   = new_q;
         end
         default: ;
      endcase
   end

   event_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .rst_n   (reset_n),
      .push_i  (push),
      .data_i  (push_ev),
      .pop_i   (ev_ready),
      .data_o  (fifo_dout),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_cnt)
   );

   // Full with a pending pop still has room for the push.
   assign drop = push && fifo_full && !(ev_ready && !fifo_empty);

   // Sticky overflow and saturating drop count; clear has priority.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ovf_q  <= 1'b0;
         drop_q <= '0;
      end else if (clr) begin
         ovf_q  <= 1'b0;
         drop_q <= '0;
      end else if (drop) begin
         ovf_q <= 1'b1;
         if (drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
      end
   end

   // Direction snapshot taken at vertical sync.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         p1_q <= '0;
         p2_q <= '0;
      end else if (frame_tick) begin
         p1_q <= dir_decode(cur_q, KEY_P1_UP, KEY_P1_LEFT,
                            KEY_P1_DOWN, KEY_P1_RIGHT);
         p2_q <= dir_decode(cur_q, KEY_P2_UP, KEY_P2_LEFT,
                            KEY_P2_DOWN, KEY_P2_RIGHT);
      end
   end

   assign ev_valid = (fifo_cnt != '0);
   assign ev_data  = fifo_dout;
   assign p1_dir   = p1_q;
   assign p2_dir   = p2_q;
   assign overflow = ovf_q;
   assign drop_cnt = drop_q;

endmodule
